fp_mult_ctrl: RTL
=================

// Module: fp_mult_ctrl
// PURPOSE
//  Sequential issue/capture stage wrapped around the combinational FP32 multiplier.
//  - Accepts an operand pair (A,B) on a valid/ready handshake and registers it onto the multiplier inputs.
//  - Holds the pair stable for CALC_CYCLES clocks (multicycle path), then captures result and flags.
//  - Presents result/flags on an output valid/ready handshake and keeps sticky status plus an op counter.
// PARAMETERS
//  CALC_CYCLES  2   clocks operands are held before capture; legal range 1..15
//  CNT_W        16  width of op_count
// PORTS
//  clk            in   1      clock, all state updates on rising edge
//  rst            in   1      asynchronous, active-high reset
//  in_valid       in   1      operand pair valid
//  in_ready       out  1      stage can accept operands this cycle
//  in_a           in   32     FP32 operand A
//  in_b           in   32     FP32 operand B
//  mul_a          out  32     registered A to multiplier input A
//  mul_b          out  32     registered B to multiplier input B
//  mul_result     in   32     multiplier result
//  mul_overflow   in   1      multiplier overflag
//  mul_underflow  in   1      multiplier underflag
//  out_valid      out  1      captured result valid
//  out_ready      in   1      consumer accepts result
//  out_result     out  32     captured FP32 product
//  out_overflow   out  1      captured overflag
//  out_underflow  out  1      captured underflag
//  sticky_over    out  1      OR of all captured overflags since reset/clear
//  sticky_under   out  1      OR of all captured underflags since reset/clear
//  clr_sticky     in   1      synchronous clear of both sticky bits
//  op_count       out  CNT_W  number of completed captures, wraps modulo 2^CNT_W
//  busy           out  1      1 when state != IDLE
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - state=IDLE; mul_a, mul_b, out_result, out_overflow, out_underflow = 0.
//    - out_valid, sticky_over, sticky_under, op_count = 0; internal down-counter = 0.
//    - Reset mid-transaction discards it; no partial output is produced.
//  - FSM states IDLE, CALC, DONE:
//    - IDLE: in_ready=1. On in_valid: latch mul_a<=in_a, mul_b<=in_b; cnt<=CALC_CYCLES-1; go to CALC.
//    - CALC: in_ready=0; mul_a/mul_b held constant.
//      - cnt!=0: cnt<=cnt-1.
//      - cnt==0: out_result<=mul_result, out_overflow<=mul_overflow, out_underflow<=mul_underflow,
//        out_valid<=1, op_count<=op_count+1; go to DONE.
//    - DONE: out_* held stable while out_valid=1. in_ready = out_ready (combinational).
//      - out_ready & in_valid: result retires, new pair latched, out_valid<=0, go to CALC (back-to-back).
//      - out_ready & !in_valid: out_valid<=0; go to IDLE.
//      - !out_ready: stay; input is not accepted.
//  - Latency: operands accepted on edge k are captured on edge k+CALC_CYCLES; out_valid high from that edge.
//  - Throughput: one op per CALC_CYCLES+1 clocks with out_ready held at 1.
//  - mul_a/mul_b keep their last operands after retirement until the next accept.
//  - Sticky bits:
//    - On capture: sticky_x <= sticky_x | mul_x.
//    - clr_sticky clears both; if clr_sticky coincides with a capture, the bits take the captured
//      flag values (clear, then set).
//  - op_count wraps from 2^CNT_W-1 to 0 with no flag.
//  - in_a/in_b are ignored whenever in_ready=0. out_ready is ignored when out_valid=0.
//  - Arithmetic is entirely in the multiplier; this block never modifies result or flag bits.
// TESTING
//  1. Reset then A=0x40400000, B=0x40000000 in IDLE, CALC_CYCLES=2
//     -> out_valid rises 2 edges after accept; out_result=0x40C00000; flags 0; op_count=1.
//  2. A=0x7F000000, B=0x7F000000
//     -> out_overflow=1, sticky_over=1; next op 1.0*1.0 (0x3F800000 both) -> out_overflow=0, sticky_over stays 1.
//  3. A=B=0x00800000 -> out_underflow=1, sticky_under=1; pulse clr_sticky in an idle cycle -> both sticky bits 0.
//  4. Hold out_ready=0 for 5 cycles after out_valid with in_valid=1
//     -> out_* stable, in_ready=0, mul_a unchanged; raise out_ready -> new pair accepted that same edge.
//  5. Back-to-back: 4 ops with in_valid=out_ready=1
//     -> results in order, one per CALC_CYCLES+1 clocks, op_count=4.
//  6. Assert rst during CALC -> out_valid=0, busy=0, op_count unchanged from 0 reset value; no stale result appears.

Source files
------------

// File: rtl/fp_mult_ctrl.sv
// fp_mult_ctrl: issue/capture stage holding operands on a multicycle FP32 multiplier and handshaking its result
module fp_mult_ctrl #(
  parameter int CALC_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_result,
  input  logic             mul_overflow,
  input  logic             mul_underflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             sticky_over,
  output logic             sticky_under,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic accept, capture, retire;
  assign retire = state == DONE && out_ready;
  assign in_ready = state == IDLE || retire;
  assign accept = in_valid && in_ready;
  assign capture = state == CALC && cnt == 4'd0;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: accept wins over retire so a waiting pair issues on the retiring edge
  always_comb begin
    state_nx = state;
    state_nx = accept ? CALC : capture ? DONE : retire ? IDLE : state;
  end
  // operand issue, hold countdown, result capture, sticky flags and op counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
      cnt <= '0;
      out_result <= '0;
      out_overflow <= 1'b0;
      out_underflow <= 1'b0;
      out_valid <= 1'b0;
      sticky_over <= 1'b0;
      sticky_under <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
        cnt <= 4'(CALC_CYCLES - 1);
      end else if (state == CALC && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (capture) begin
        out_result <= mul_result;
        out_overflow <= mul_overflow;
        out_underflow <= mul_underflow;
        out_valid <= 1'b1;
        op_count <= op_count + CNT_W'(1);
      end else if (retire) out_valid <= 1'b0;
      sticky_over <= (sticky_over & ~clr_sticky) | (capture & mul_overflow);
      sticky_under <= (sticky_under & ~clr_sticky) | (capture & mul_underflow);
    end
endmodule
